// File: rtl/atm_controller.sv
// ATM transaction controller: card detect, 4-digit PIN entry with
// 3-strike lockout, deposit/withdrawal against an internal balance.
// Optional inactivity timeout is compiled in with `define ATM_TIMEOUT_EN.
//
// Ports:
//   clk, rst               clock, synchronous active-high reset
//   tarjeta_recibida       card inserted (level)
//   tipo_trans             0 deposit, 1 withdrawal (sampled with monto_stb)
//   digito, add_digit      keypad digit and its strobe (edge detected)
//   monto_stb, monto       amount strobe (edge detected) and amount
//   balance_actualizado    pulse: balance changed
//   entregar_dinero        pulse: dispense cash
//   pin_incorrecto         pulse: PIN mismatch
//   advertencia            level: two consecutive failed PINs
//   bloqueo                level: locked until rst
//   fondos_insuficientes   pulse: withdrawal rejected
//   balance                current balance

module atm_controller #(
  parameter logic [15:0] PIN            = 16'h4756,
  parameter logic [63:0] BALANCE_INIT   = 64'd50000,
  parameter int unsigned TIMEOUT_CYCLES = 1000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        tarjeta_recibida,
  input  logic        tipo_trans,
  input  logic [3:0]  digito,
  input  logic        add_digit,
  input  logic        monto_stb,
  input  logic [31:0] monto,
  output logic        balance_actualizado,
  output logic        entregar_dinero,
  output logic        pin_incorrecto,
  output logic        advertencia,
  output logic        bloqueo,
  output logic        fondos_insuficientes,
  output logic [63:0] balance
);

  typedef enum logic [2:0] {
    ESPERANDO_TARJETA,
    VERIFICAR_PIN,
    COMPARAR,
    ESPERAR_MONTO,
    DEPOSITO,
    RETIRO,
    BLOQUEO
  } state_t;

  state_t      state;
  logic        add_prev;
  logic        monto_prev;
  logic        add_edge;
  logic        monto_edge;
  logic [15:0] pin_buf;
  logic [2:0]  count;
  logic [1:0]  attempts;
  logic [31:0] monto_q;
  logic        tipo_q;
  logic [63:0] monto_ext;
  logic        timeout;

  // A strobe held high counts once: only a 0->1 change is an event.
  assign add_edge   = add_digit & ~add_prev;
  assign monto_edge = monto_stb & ~monto_prev;
  assign monto_ext  = {32'd0, monto_q};

`ifdef ATM_TIMEOUT_EN
  logic [31:0] tmr;
  logic        waiting;

  assign waiting = (state == VERIFICAR_PIN) ||
                   (state == ESPERAR_MONTO);
  assign timeout = waiting &&
                   (tmr == 32'(TIMEOUT_CYCLES - 1));

  // Every entry into a waiting state comes from a non-waiting
  // state, so clearing outside them covers the restart on entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      tmr <= '0;
    end else if (!waiting || add_edge || monto_edge || timeout) begin
      tmr <= '0;
    end else begin
      tmr <= tmr + 32'd1;
    end
  end
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state                <= ESPERANDO_TARJETA;
      add_prev             <= 1'b0;
      monto_prev           <= 1'b0;
      pin_buf              <= '0;
      count                <= '0;
      attempts             <= '0;
      monto_q              <= '0;
      tipo_q               <= 1'b0;
      balance              <= BALANCE_INIT;
      balance_actualizado  <= 1'b0;
      entregar_dinero      <= 1'b0;
      pin_incorrecto       <= 1'b0;
      advertencia          <= 1'b0;
      bloqueo              <= 1'b0;
      fondos_insuficientes <= 1'b0;
    end else begin
      add_prev             <= add_digit;
      monto_prev           <= monto_stb;
      balance_actualizado  <= 1'b0;
      entregar_dinero      <= 1'b0;
      pin_incorrecto       <= 1'b0;
      fondos_insuficientes <= 1'b0;

      unique case (state)
        ESPERANDO_TARJETA: begin
          if (tarjeta_recibida) begin
            state   <= VERIFICAR_PIN;
            count   <= '0;
            pin_buf <= '0;
          end
        end

        VERIFICAR_PIN: begin
          if (add_edge) begin
            pin_buf <= {pin_buf[11:0], digito};
            count   <= count + 3'd1;
            if (count == 3'd3) begin
              state <= COMPARAR;
            end
          end else if (timeout) begin
            // Abandon the partial PIN; attempts are kept.
            state   <= ESPERANDO_TARJETA;
            count   <= '0;
            pin_buf <= '0;
          end
        end

        COMPARAR: begin
          if (pin_buf == PIN) begin
            attempts    <= '0;
            advertencia <= 1'b0;
            state       <= ESPERAR_MONTO;
          end else begin
            attempts       <= attempts + 2'd1;
            pin_incorrecto <= 1'b1;
            if (attempts == 2'd2) begin
              bloqueo     <= 1'b1;
              advertencia <= 1'b0;
              state       <= BLOQUEO;
            end else begin
              if (attempts == 2'd1) begin
                advertencia <= 1'b1;
              end
              count   <= '0;
              pin_buf <= '0;
              state   <= VERIFICAR_PIN;
            end
          end
        end

        ESPERAR_MONTO: begin
          if (monto_edge) begin
            monto_q <= monto;
            tipo_q  <= tipo_trans;
            state   <= tipo_trans ? RETIRO : DEPOSITO;
          end else if (timeout) begin
            state <= ESPERANDO_TARJETA;
          end
        end

        DEPOSITO: begin
          // Wraps modulo 2^64.
          balance             <= balance + monto_ext;
          balance_actualizado <= 1'b1;
          state               <= ESPERANDO_TARJETA;
        end

        RETIRO: begin
          if (monto_ext > balance) begin
            fondos_insuficientes <= 1'b1;
          end else begin
            balance             <= balance - monto_ext;
            balance_actualizado <= 1'b1;
            entregar_dinero     <= 1'b1;
          end
          state <= ESPERANDO_TARJETA;
        end

        BLOQUEO: begin
          state <= BLOQUEO;
        end

        default: begin
          state <= ESPERANDO_TARJETA;
        end
      endcase
    end
  end

  // tipo_q is kept for observability of the latched transaction.
  logic unused_tipo;
  assign unused_tipo = tipo_q;

endmodule

// File: tb/tb_atm_controller.sv
// Directed self-checking bench for atm_controller.
// Pulses are counted on the falling edge; checks compare count deltas.

module tb_atm_controller;

  logic        clk = 1'b0;
  logic        rst;
  logic        tarjeta_recibida;
  logic        tipo_trans;
  logic [3:0]  digito;
  logic        add_digit;
  logic        monto_stb;
  logic [31:0] monto;
  logic        balance_actualizado;
  logic        entregar_dinero;
  logic        pin_incorrecto;
  logic        advertencia;
  logic        bloqueo;
  logic        fondos_insuficientes;
  logic [63:0] balance;

  int checks   = 0;
  int failures = 0;

  int c_ba = 0;
  int c_ed = 0;
  int c_pi = 0;
  int c_fi = 0;
  int c_both = 0;
  int s_ba, s_ed, s_pi, s_fi, s_both;

  atm_controller #(
    .PIN(16'h4756),
    .BALANCE_INIT(64'd50000),
    .TIMEOUT_CYCLES(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .tarjeta_recibida(tarjeta_recibida),
    .tipo_trans(tipo_trans),
    .digito(digito),
    .add_digit(add_digit),
    .monto_stb(monto_stb),
    .monto(monto),
    .balance_actualizado(balance_actualizado),
    .entregar_dinero(entregar_dinero),
    .pin_incorrecto(pin_incorrecto),
    .advertencia(advertencia),
    .bloqueo(bloqueo),
    .fondos_insuficientes(fondos_insuficientes),
    .balance(balance)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (balance_actualizado === 1'b1) c_ba++;
    if (entregar_dinero === 1'b1) c_ed++;
    if (pin_incorrecto === 1'b1) c_pi++;
    if (fondos_insuficientes === 1'b1) c_fi++;
    if (balance_actualizado === 1'b1 &&
        entregar_dinero === 1'b1) c_both++;
  end

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d",
             tag, obs, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic snap();
    s_ba = c_ba;
    s_ed = c_ed;
    s_pi = c_pi;
    s_fi = c_fi;
    s_both = c_both;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(2);
    rst = 1'b0;
    step(1);
  endtask

  task automatic card();
    tarjeta_recibida = 1'b1;
    step(1);
    tarjeta_recibida = 1'b0;
    step(1);
  endtask

  task automatic press(input logic [3:0] d);
    digito = d;
    add_digit = 1'b1;
    step(1);
    add_digit = 1'b0;
    step(1);
  endtask

  task automatic enter_pin(input logic [15:0] p);
    press(p[15:12]);
    press(p[11:8]);
    press(p[7:4]);
    press(p[3:0]);
    step(2);
  endtask

  task automatic amount(input logic t, input logic [31:0] m);
    tipo_trans = t;
    monto = m;
    monto_stb = 1'b1;
    step(1);
    monto_stb = 1'b0;
    step(3);
  endtask

  initial begin
    rst = 1'b1;
    tarjeta_recibida = 1'b0;
    tipo_trans = 1'b0;
    digito = 4'd0;
    add_digit = 1'b0;
    monto_stb = 1'b0;
    monto = 32'd0;
    step(2);
    rst = 1'b0;
    step(1);

    chk("rst_balance", balance, 64'd50000);
    chk("rst_bloqueo", bloqueo, 1'b0);
    chk("rst_advert", advertencia, 1'b0);
    chk("rst_pulses", c_ba + c_ed + c_pi + c_fi, 0);

    snap();
    card();
    enter_pin(16'h4756);
    amount(1'b0, 32'd10000);
    chk("dep_pin_ok", c_pi - s_pi, 0);
    chk("dep_ba", c_ba - s_ba, 1);
    chk("dep_ed", c_ed - s_ed, 0);
    chk("dep_bal", balance, 64'd60000);

    do_reset();
    snap();
    card();
    enter_pin(16'h4756);
    amount(1'b1, 32'd20000);
    chk("wd_both", c_both - s_both, 1);
    chk("wd_ed", c_ed - s_ed, 1);
    chk("wd_bal", balance, 64'd30000);

    do_reset();
    snap();
    card();
    enter_pin(16'h4756);
    amount(1'b1, 32'd50001);
    chk("nsf_fi", c_fi - s_fi, 1);
    chk("nsf_ed", c_ed - s_ed, 0);
    chk("nsf_ba", c_ba - s_ba, 0);
    chk("nsf_bal", balance, 64'd50000);

    snap();
    card();
    enter_pin(16'h4756);
    amount(1'b1, 32'd50000);
    chk("exact_both", c_both - s_both, 1);
    chk("exact_fi", c_fi - s_fi, 0);
    chk("exact_bal", balance, 64'd0);

    do_reset();
    snap();
    card();
    enter_pin(16'h1111);
    chk("w1_pi", c_pi - s_pi, 1);
    chk("w1_adv", advertencia, 1'b0);
    press(4'h1);
    press(4'h1);
    press(4'h1);
    digito = 4'h1;
    add_digit = 1'b1;
    step(1);
    chk("lat_pi_early", pin_incorrecto, 1'b0);
    add_digit = 1'b0;
    step(1);
    chk("lat_pi_on", pin_incorrecto, 1'b1);
    chk("w2_adv", advertencia, 1'b1);
    step(1);
    chk("lat_pi_off", pin_incorrecto, 1'b0);
    step(1);
    chk("w2_pi", c_pi - s_pi, 2);
    enter_pin(16'h4756);
    chk("ok_adv_clr", advertencia, 1'b0);
    snap();
    amount(1'b0, 32'd0);
    chk("dep0_ba", c_ba - s_ba, 1);
    chk("dep0_bal", balance, 64'd50000);

    card();
    enter_pin(16'h9999);
    chk("clr_lock", bloqueo, 1'b0);
    chk("clr_adv", advertencia, 1'b0);
    enter_pin(16'h4756);
    snap();
    amount(1'b1, 32'd0);
    chk("wd0_ba", c_ba - s_ba, 1);
    chk("wd0_ed", c_ed - s_ed, 1);
    chk("wd0_bal", balance, 64'd50000);

    do_reset();
    snap();
    card();
    enter_pin(16'h1111);
    enter_pin(16'h2222);
    enter_pin(16'h3333);
    chk("lock_pi", c_pi - s_pi, 3);
    chk("lock_on", bloqueo, 1'b1);
    step(5);
    snap();
    card();
    enter_pin(16'h4756);
    amount(1'b0, 32'd100);
    chk("lock_held", bloqueo, 1'b1);
    chk("lock_bal", balance, 64'd50000);
    chk("lock_ba", c_ba - s_ba, 0);
    chk("lock_pi2", c_pi - s_pi, 0);
    do_reset();
    chk("unlock", bloqueo, 1'b0);
    chk("unlock_bal", balance, 64'd50000);

    card();
    press(4'h4);
    press(4'h7);
    do_reset();
    snap();
    card();
    enter_pin(16'h4756);
    amount(1'b0, 32'd1);
    chk("midrst_pi", c_pi - s_pi, 0);
    chk("midrst_bal", balance, 64'd50001);

    snap();
    card();
    digito = 4'h4;
    add_digit = 1'b1;
    step(3);
    add_digit = 1'b0;
    step(1);
    press(4'h7);
    press(4'h5);
    press(4'h6);
    step(2);
    chk("hold_pi", c_pi - s_pi, 0);
    amount(1'b0, 32'd5);
    chk("hold_bal", balance, 64'd50006);

    snap();
    card();
    amount(1'b0, 32'd9);
    chk("ign_ba", c_ba - s_ba, 0);
    enter_pin(16'h4756);
    press(4'h3);
    amount(1'b0, 32'd9);
    chk("ign_ba2", c_ba - s_ba, 1);
    chk("ign_bal", balance, 64'd50015);

`ifdef ATM_TIMEOUT_EN
    snap();
    card();
    step(10);
    enter_pin(16'h4756);
    amount(1'b0, 32'd7);
    chk("tmo_bal", balance, 64'd50015);
    chk("tmo_pi", c_pi - s_pi, 0);
`else
    snap();
    card();
    step(20);
    enter_pin(16'h4756);
    amount(1'b0, 32'd7);
    chk("notmo_bal", balance, 64'd50022);
    chk("notmo_pi", c_pi - s_pi, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
